// File: rtl/sha256_msg_server.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_server
//  Description : Bus responder that serves 32-bit SHA-256 message words for a
//                double-SHA-256 of a Bitcoin header. It holds the 76-byte
//                header (no nonce), a nonce counter and the first-pass digest,
//                and assembles header chunk 0, header chunk 1 (nonce plus
//                padding) and the second-pass digest block on demand.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_server #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  // header loader
  input  logic         ld_start,
  input  logic         ld_valid,
  input  logic [7:0]   ld_byte,
  output logic         hdr_valid,
  // nonce controller
  input  logic         nonce_load,
  input  logic [31:0]  nonce_in,
  input  logic         nonce_inc,
  output logic [31:0]  nonce_out,
  output logic         nonce_wrap,
  // block selection and first-pass digest
  input  logic [1:0]   chunk_sel,
  input  logic [255:0] digest_in,
  // word-fetch bus
  input  logic [3:0]   addr,
  input  logic         rq,
  output logic         rdy,
  output logic [31:0]  data
);

  // Wait-counter preload; LATENCY is limited to 1..15 so 4 bits suffice.
  localparam logic [3:0]  C_LAT_M1     = 4'(LATENCY - 1);
  localparam int          C_HDR_WORDS  = 19;
  localparam logic [6:0]  C_LAST_BYTE  = 7'd75;
  localparam logic [6:0]  C_HDR_BYTES  = 7'd76;
  localparam logic [31:0] C_PAD_ONE    = 32'h8000_0000;
  localparam logic [31:0] C_LEN_HDR    = 32'h0000_0280;  // 640-bit message
  localparam logic [31:0] C_LEN_DIGEST = 32'h0000_0100;  // 256-bit message

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Header storage and loader state
  logic [31:0] r_hdr [0:C_HDR_WORDS-1];
  logic [6:0]  r_byte_cnt;
  logic        r_hdr_valid;

  // Nonce counter
  logic [31:0] r_nonce;
  logic        r_nonce_wrap;

  // Responder state
  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_word;
  logic        r_rdy;
  logic [31:0] r_data;

  // Combinational helpers
  logic [4:0]  w_wr_word;
  logic [4:0]  w_wr_lsb;
  logic [31:0] w_nonce_swap;
  logic [2:0]  w_dig_sel;
  logic [31:0] w_word;

  assign hdr_valid  = r_hdr_valid;
  assign nonce_out  = r_nonce;
  assign nonce_wrap = r_nonce_wrap;
  assign rdy        = r_rdy;
  assign data       = r_data;

  // Byte n lands in word n/4; lane 0 is the most significant byte.
  assign w_wr_word = r_byte_cnt[6:2];
  assign w_wr_lsb  = {~r_byte_cnt[1:0], 3'b000};

  // The nonce sits little-endian in the header, so it is byte-swapped into
  // the big-endian message word.
  assign w_nonce_swap = {r_nonce[7:0], r_nonce[15:8], r_nonce[23:16], r_nonce[31:24]};

  // Digest word 0 occupies the top 32 bits, so word n starts at bit 32*(7-n).
  assign w_dig_sel = ~addr[2:0];

  // Header loader: big-endian byte packing, bytes past the 76th are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt  <= '0;
      r_hdr_valid <= 1'b0;
      for (int i = 0; i < C_HDR_WORDS; i++) begin
        r_hdr[i] <= '0;
      end
    end else if (ld_start) begin
      r_byte_cnt  <= '0;
      r_hdr_valid <= 1'b0;
    end else if (ld_valid && (r_byte_cnt < C_HDR_BYTES)) begin
      r_hdr[w_wr_word][w_wr_lsb +: 8] <= ld_byte;
      r_byte_cnt                      <= r_byte_cnt + 7'd1;
      if (r_byte_cnt == C_LAST_BYTE) begin
        r_hdr_valid <= 1'b1;
      end
    end
  end

  // Nonce counter: load beats increment; wrap flag is a registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nonce      <= '0;
      r_nonce_wrap <= 1'b0;
    end else if (nonce_load) begin
      r_nonce      <= nonce_in;
      r_nonce_wrap <= 1'b0;
    end else if (nonce_inc) begin
      r_nonce      <= r_nonce + 32'd1;
      r_nonce_wrap <= (r_nonce == 32'hFFFF_FFFF);
    end else begin
      r_nonce_wrap <= 1'b0;
    end
  end

  // Word map: selects the message word for the current chunk and address.
  always_comb begin
    w_word = '0;
    case (chunk_sel)
      2'd0: begin
        w_word = r_hdr[{1'b0, addr}];
      end
      2'd1: begin
        case (addr)
          4'd0:    w_word = r_hdr[16];
          4'd1:    w_word = r_hdr[17];
          4'd2:    w_word = r_hdr[18];
          4'd3:    w_word = w_nonce_swap;
          4'd4:    w_word = C_PAD_ONE;
          4'd15:   w_word = C_LEN_HDR;
          default: w_word = '0;
        endcase
      end
      2'd2: begin
        if (!addr[3]) begin
          w_word = digest_in[{w_dig_sel, 5'b00000} +: 32];
        end else if (addr == 4'd8) begin
          w_word = C_PAD_ONE;
        end else if (addr == 4'd15) begin
          w_word = C_LEN_DIGEST;
        end else begin
          w_word = '0;
        end
      end
      default: begin
        w_word = '0;
      end
    endcase
  end

  // Responder FSM: latch on acceptance, pulse rdy once, then wait for rq low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_word     <= '0;
      r_rdy      <= 1'b0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdy  <= 1'b0;
          r_data <= '0;
          if (rq) begin
            r_word <= w_word;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_rdy   <= 1'b1;
              r_data  <= w_word;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= C_LAT_M1;
            end
          end
        end
        S_WAIT: begin
          // A request withdrawn during the wait is dropped silently.
          if (!rq) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_rdy   <= 1'b1;
            r_data  <= r_word;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_rdy   <= 1'b0;
          r_data  <= '0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_rdy  <= 1'b0;
          r_data <= '0;
          if (!rq) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_msg_server
//  Description : Directed self-checking bench for sha256_msg_server. Two
//                instances (LATENCY=1 and LATENCY=3) share the loader, nonce,
//                digest and address inputs and have separate rq lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_server;

  logic         clk;
  logic         rst_n;
  logic         ld_start;
  logic         ld_valid;
  logic [7:0]   ld_byte;
  logic         nonce_load;
  logic [31:0]  nonce_in;
  logic         nonce_inc;
  logic [1:0]   chunk_sel;
  logic [255:0] digest_in;
  logic [3:0]   addr;
  logic         rq1;
  logic         rq3;

  logic         hdr_valid1, hdr_valid3;
  logic [31:0]  nonce_out1, nonce_out3;
  logic         nonce_wrap1, nonce_wrap3;
  logic         rdy1, rdy3;
  logic [31:0]  data1, data3;

  int n_cmp;
  int n_err;
  int pulses;

  sha256_msg_server #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .hdr_valid(hdr_valid1),
    .nonce_load(nonce_load), .nonce_in(nonce_in), .nonce_inc(nonce_inc),
    .nonce_out(nonce_out1), .nonce_wrap(nonce_wrap1),
    .chunk_sel(chunk_sel), .digest_in(digest_in),
    .addr(addr), .rq(rq1), .rdy(rdy1), .data(data1)
  );

  sha256_msg_server #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .hdr_valid(hdr_valid3),
    .nonce_load(nonce_load), .nonce_in(nonce_in), .nonce_inc(nonce_inc),
    .nonce_out(nonce_out3), .nonce_wrap(nonce_wrap3),
    .chunk_sel(chunk_sel), .digest_in(digest_in),
    .addr(addr), .rq(rq3), .rdy(rdy3), .data(data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hdr();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 76; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(i);
      if (i == 75) chk("hdr_valid before last byte", 32'(hdr_valid1), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    chk("hdr_valid after 76 bytes", 32'(hdr_valid1), 32'd1);
  endtask

  // One request on the selected instance: checks latency, word and rdy drop.
  task automatic do_read(input bit use3, input logic [1:0] cs, input logic [3:0] a,
                         input logic [31:0] exp, input string tag);
    int  n;
    int  lat;
    bit  got;
    chunk_sel = cs;
    addr      = a;
    if (use3) rq3 = 1'b1; else rq1 = 1'b1;
    lat = use3 ? 3 : 1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (use3 ? rdy3 : rdy1) got = 1'b1;
    end
    if (got) pulses++;
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " data"}, use3 ? data3 : data1, exp);
    rq1 = 1'b0;
    rq3 = 1'b0;
    tick();
    chk({tag, " rdy drop"}, 32'(use3 ? rdy3 : rdy1), 32'd0);
    chk({tag, " data idle"}, use3 ? data3 : data1, 32'd0);
    tick();
  endtask

  initial begin
    int n;
    int cnt;
    n_cmp = 0;
    n_err = 0;
    pulses = 0;
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
    nonce_load = 1'b0; nonce_in = '0; nonce_inc = 1'b0;
    chunk_sel = '0; digest_in = '0; addr = '0; rq1 = 1'b0; rq3 = 1'b0;
    for (int k = 0; k < 8; k++) digest_in[255 - 32*k -: 32] = 32'hA000_0000 + 32'(k);

    repeat (3) @(posedge clk);
    #1;
    chk("reset rdy", 32'(rdy1), 32'd0);
    chk("reset data", data1, 32'd0);
    chk("reset hdr_valid", 32'(hdr_valid1), 32'd0);
    chk("reset nonce", nonce_out1, 32'd0);
    chk("reset nonce_wrap", 32'(nonce_wrap1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Header load, then an extra byte that must be ignored
    load_hdr();
    chk("hdr_valid lat3 inst", 32'(hdr_valid3), 32'd1);
    ld_valid = 1'b1; ld_byte = 8'hFF;
    tick();
    ld_valid = 1'b0;

    // Chunk 0, LATENCY=1
    do_read(1'b0, 2'd0, 4'd0,  32'h0001_0203, "c0 a0");
    do_read(1'b0, 2'd0, 4'd15, 32'h3C3D_3E3F, "c0 a15");

    // Chunk 1
    nonce_in = 32'h1234_5678; nonce_load = 1'b1;
    tick();
    nonce_load = 1'b0;
    chk("nonce loaded", nonce_out1, 32'h1234_5678);
    do_read(1'b0, 2'd1, 4'd0,  32'h4041_4243, "c1 a0");
    do_read(1'b0, 2'd1, 4'd2,  32'h4849_4A4B, "c1 a2");
    do_read(1'b0, 2'd1, 4'd3,  32'h7856_3412, "c1 a3");
    do_read(1'b0, 2'd1, 4'd4,  32'h8000_0000, "c1 a4");
    do_read(1'b0, 2'd1, 4'd9,  32'h0000_0000, "c1 a9");
    do_read(1'b0, 2'd1, 4'd15, 32'h0000_0280, "c1 a15");

    // Digest block and reserved chunk
    do_read(1'b0, 2'd2, 4'd0,  32'hA000_0000, "c2 a0");
    do_read(1'b0, 2'd2, 4'd7,  32'hA000_0007, "c2 a7");
    do_read(1'b0, 2'd2, 4'd8,  32'h8000_0000, "c2 a8");
    do_read(1'b0, 2'd2, 4'd15, 32'h0000_0100, "c2 a15");
    do_read(1'b0, 2'd3, 4'd4,  32'h0000_0000, "c3 a4");

    // ld_start beats ld_valid; reload the header afterwards
    ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hEE;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("ld_start clears hdr_valid", 32'(hdr_valid1), 32'd0);
    load_hdr();
    do_read(1'b0, 2'd0, 4'd0, 32'h0001_0203, "reload c0 a0");

    // LATENCY=3: rq held high after the pulse yields no second rdy
    chunk_sel = 2'd0; addr = 4'd1; rq3 = 1'b1;
    n = 0;
    while (!rdy3 && n < 20) begin tick(); n++; end
    chk("hold first latency", 32'(n), 32'd3);
    chk("hold first data", data3, 32'h0405_0607);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (rdy3) cnt++; end
    chk("hold no second rdy", 32'(cnt), 32'd0);
    rq3 = 1'b0;
    tick();
    rq3 = 1'b1; addr = 4'd2;
    n = 0;
    while (!rdy3 && n < 20) begin tick(); n++; end
    chk("hold re-request latency", 32'(n), 32'd3);
    chk("hold re-request data", data3, 32'h0809_0A0B);
    rq3 = 1'b0;
    tick(); tick();

    // LATENCY=3: rq dropped in the 2nd wait cycle aborts
    addr = 4'd5; rq3 = 1'b1;
    tick();          // accepted
    tick();          // first wait cycle done
    rq3 = 1'b0;      // low during the second wait cycle
    cnt = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (rdy3) cnt++; end
    chk("abort no rdy", 32'(cnt), 32'd0);
    do_read(1'b1, 2'd0, 4'd5, 32'h1415_1617, "after abort");

    // Full 16-word fetch of chunk 0 on the LATENCY=3 instance
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      do_read(1'b1, 2'd0, 4'(k),
              {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, $sformatf("fetch w%0d", k));
    end
    chk("fetch rdy pulses", 32'(pulses), 32'd16);

    // Nonce wrap
    nonce_in = 32'hFFFF_FFFF; nonce_load = 1'b1;
    tick();
    nonce_load = 1'b0; nonce_inc = 1'b1;
    tick();
    nonce_inc = 1'b0;
    chk("wrap nonce", nonce_out1, 32'd0);
    chk("wrap pulse", 32'(nonce_wrap1), 32'd1);
    tick();
    chk("wrap pulse ends", 32'(nonce_wrap1), 32'd0);

    // Load beats increment
    nonce_in = 32'd5; nonce_load = 1'b1; nonce_inc = 1'b1;
    tick();
    nonce_load = 1'b0; nonce_inc = 1'b0;
    chk("load over inc", nonce_out1, 32'd5);

    // Increment during the wait uses the pre-increment nonce
    chunk_sel = 2'd1; addr = 4'd3; rq3 = 1'b1;
    tick();
    nonce_inc = 1'b1;
    tick();
    nonce_inc = 1'b0;
    n = 2;
    while (!rdy3 && n < 20) begin tick(); n++; end
    chk("inc in wait latency", 32'(n), 32'd3);
    chk("inc in wait data", data3, 32'h0500_0000);
    chk("inc in wait nonce", nonce_out3, 32'd6);
    rq3 = 1'b0;
    tick(); tick();

    // Asynchronous reset during a wait
    chunk_sel = 2'd0; addr = 4'd0; rq3 = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst rdy", 32'(rdy3), 32'd0);
    chk("async rst data", data3, 32'd0);
    chk("async rst hdr_valid", 32'(hdr_valid3), 32'd0);
    chk("async rst nonce", nonce_out3, 32'd0);
    rq3 = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (rdy3) cnt++; end
    chk("post rst no rdy", 32'(cnt), 32'd0);
    do_read(1'b1, 2'd0, 4'd0, 32'h0000_0000, "post rst cleared hdr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
